cam_req_sequencer: RTL and testbench

- Upstream front-end for the 32-entry x 32-bit CAM.
- Accepts read, write and search requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues them one at a time onto the CAM's read/write/search enable ports.
- Captures the CAM's read/search result and returns it on a valid/ready response channel, so requesters never drive CAM enables directly.

---
 rtl/cam_req_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_cam_req_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_req_sequencer.sv
// Request sequencer in front of the 32x32 CAM: buffers read/write/search ops in a FIFO,
// issues them one at a time and returns read/search results. Define CAM_REQ_SEQ_STATS_EN for hit/miss counters.
module cam_req_sequencer #(
  parameter int DEPTH   = 4,
  parameter int CAM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [4:0]  req_index_i,
  input  logic [31:0] req_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_hit_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_is_search_o,
  output logic        cam_read_enable_o,
  output logic        cam_write_enable_o,
  output logic        cam_search_enable_o,
  output logic [4:0]  cam_read_index_o,
  output logic [4:0]  cam_write_index_o,
  output logic [31:0] cam_write_data_o,
  output logic [31:0] cam_search_data_o,
  input  logic        cam_read_valid_i,
  input  logic [31:0] cam_read_value_i,
  input  logic        cam_search_valid_i,
  input  logic [4:0]  cam_search_index_i
`ifdef CAM_REQ_SEQ_STATS_EN
  ,
  output logic [15:0] stat_hits_o,
  output logic [15:0] stat_misses_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_SR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [31:0] data;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ready_q;
  logic          pend_search_q;
  logic          rsp_valid_q, rsp_hit_q, rsp_is_search_q;
  logic [31:0]   rsp_data_q;
  logic [4:0]    rd_idx_q, wr_idx_q;
  logic [31:0]   wr_data_q, sr_data_q;
  logic          push, pop, rd_en, wr_en, sr_en, capture;
  req_t          head;

  assign head = mem_q[rd_ptr_q];
  assign push = req_valid_i && ready_q;
  assign pop  = (state_q == ST_ISSUE);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    sr_en   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (count_q != '0) state_d = ST_ISSUE;
      ST_ISSUE: begin
        case (head.op)
          OP_RD, OP_SR: begin
            rd_en   = (head.op == OP_RD);
            sr_en   = (head.op == OP_SR);
            wcnt_d  = CW'(CAM_LAT - 1);
            state_d = ST_WAIT;
          end
          default: begin
            // writes stream back-to-back; the reserved op is popped silently
            wr_en   = (head.op == OP_WR);
            state_d = (count_d != '0) ? ST_ISSUE : ST_IDLE;
          end
        endcase
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - CW'(1);
        end
      end
      ST_RESP: if (rsp_ready_i) state_d = (count_q != '0) ? ST_ISSUE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{op: req_op_i, idx: req_index_i, data: req_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= ST_IDLE;
      wcnt_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      ready_q         <= 1'b0;
      pend_search_q   <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_is_search_q <= 1'b0;
      rsp_data_q      <= '0;
      rd_idx_q        <= '0;
      wr_idx_q        <= '0;
      wr_data_q       <= '0;
      sr_data_q       <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
      ready_q <= (count_d != CNT_FULL);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (pop)  pend_search_q <= (head.op == OP_SR);
      if (rd_en) rd_idx_q <= head.idx;
      if (wr_en) begin
        wr_idx_q  <= head.idx;
        wr_data_q <= head.data;
      end
      if (sr_en) sr_data_q <= head.data;
      if (capture) begin
        rsp_valid_q     <= 1'b1;
        rsp_is_search_q <= pend_search_q;
        rsp_hit_q       <= pend_search_q ? cam_search_valid_i : cam_read_valid_i;
        rsp_data_q      <= pend_search_q ? {27'b0, cam_search_index_i} : cam_read_value_i;
      end else if (state_q == ST_RESP && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef CAM_REQ_SEQ_STATS_EN
  logic [15:0] hits_q, misses_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (capture && pend_search_q) begin
      if (cam_search_valid_i && hits_q != 16'hFFFF)         hits_q   <= hits_q + 16'd1;
      else if (!cam_search_valid_i && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;
`endif

  // index/data buses show the head entry only while its enable is high, else the last issued value
  assign req_ready_o         = ready_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_hit_o           = rsp_hit_q;
  assign rsp_data_o          = rsp_data_q;
  assign rsp_is_search_o     = rsp_is_search_q;
  assign cam_read_enable_o   = rd_en;
  assign cam_write_enable_o  = wr_en;
  assign cam_search_enable_o = sr_en;
  assign cam_read_index_o    = rd_en ? head.idx : rd_idx_q;
  assign cam_write_index_o   = wr_en ? head.idx : wr_idx_q;
  assign cam_write_data_o    = wr_en ? head.data : wr_data_q;
  assign cam_search_data_o   = sr_en ? head.data : sr_data_q;

endmodule

// File: tb/tb_cam_req_sequencer.sv
// Bench for cam_req_sequencer: behavioural CAM, reference memory and an in-order response scoreboard.
module tb_cam_req_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_op_i;
  logic [4:0]  req_index_i;
  logic [31:0] req_data_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_hit_o, rsp_is_search_o;
  logic [31:0] rsp_data_o;
  logic        cam_read_enable_o, cam_write_enable_o, cam_search_enable_o;
  logic [4:0]  cam_read_index_o, cam_write_index_o;
  logic [31:0] cam_write_data_o, cam_search_data_o;
  logic        cam_read_valid_i = 1'b0;
  logic [31:0] cam_read_value_i = '0;
  logic        cam_search_valid_i = 1'b0;
  logic [4:0]  cam_search_index_i = '0;
`ifdef CAM_REQ_SEQ_STATS_EN
  logic [15:0] stat_hits_o, stat_misses_o;
`endif

  always #5 clk_i = ~clk_i;

  cam_req_sequencer #(.DEPTH(4), .CAM_LAT(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_index_i(req_index_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
    .rsp_data_o(rsp_data_o), .rsp_is_search_o(rsp_is_search_o),
    .cam_read_enable_o(cam_read_enable_o), .cam_write_enable_o(cam_write_enable_o),
    .cam_search_enable_o(cam_search_enable_o),
    .cam_read_index_o(cam_read_index_o), .cam_write_index_o(cam_write_index_o),
    .cam_write_data_o(cam_write_data_o), .cam_search_data_o(cam_search_data_o),
    .cam_read_valid_i(cam_read_valid_i), .cam_read_value_i(cam_read_value_i),
    .cam_search_valid_i(cam_search_valid_i), .cam_search_index_i(cam_search_index_i)
`ifdef CAM_REQ_SEQ_STATS_EN
    , .stat_hits_o(stat_hits_o), .stat_misses_o(stat_misses_o)
`endif
  );

  // Behavioural CAM with one cycle of latency; lowest matching index wins a search.
  logic [31:0] cam_mem [32];
  logic        cam_vld [32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      cam_mem[i] = '0;
      cam_vld[i] = 1'b0;
    end
  end

  always @(posedge clk_i) begin
    cam_read_valid_i   <= cam_read_enable_o && cam_vld[cam_read_index_o];
    cam_read_value_i   <= cam_mem[cam_read_index_o];
    cam_search_valid_i <= 1'b0;
    cam_search_index_i <= '0;
    if (cam_search_enable_o) begin
      for (int i = 31; i >= 0; i--) begin
        if (cam_vld[i] && cam_mem[i] == cam_search_data_o) begin
          cam_search_valid_i <= 1'b1;
          cam_search_index_i <= 5'(i);
        end
      end
    end
    if (cam_write_enable_o) begin
      cam_mem[cam_write_index_o] <= cam_write_data_o;
      cam_vld[cam_write_index_o] <= 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "global timeout");
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference state advanced in arrival order; expected entries are {hit, data, is_search}.
  logic [31:0] ref_mem [32];
  logic        ref_vld [32];
  logic [33:0] exp_q [$];

  int          cyc = 0, en_cnt = 0, onehot_err = 0, we_cyc = 0, rd_cyc = 0;
  logic [4:0]  wr_idx_seen = '0, rd_idx_seen = '0;
  logic [31:0] wr_data_seen = '0;
  logic        done = 1'b0;

  function automatic logic [33:0] ref_search(input logic [31:0] key);
    for (int i = 0; i < 32; i++)
      if (ref_vld[i] && ref_mem[i] == key) return {1'b1, 32'(i), 1'b1};
    return {1'b0, 32'd0, 1'b1};
  endfunction

  task automatic push_req(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data);
    int n = 0;
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_index_i = idx;
    req_data_i  = data;
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) chk_val("push_timeout", 0, 1);
    else begin
      case (op)
        2'b00: exp_q.push_back({ref_vld[idx], ref_mem[idx], 1'b0});
        2'b01: begin
          ref_mem[idx] = data;
          ref_vld[idx] = 1'b1;
        end
        2'b10: exp_q.push_back(ref_search(data));
        default: ;
      endcase
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) chk_val({tag, "_drain_timeout"}, exp_q.size(), 0);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic chk_zero(input string p);
    chk_val({p, "_ctrl"}, {req_ready_o, rsp_valid_o, rsp_hit_o, rsp_is_search_o,
            cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}, 0);
    chk_val({p, "_rsp_data"}, rsp_data_o, 0);
    chk_val({p, "_cam_bus"}, {cam_read_index_o, cam_write_index_o, cam_write_data_o}, 0);
    chk_val({p, "_cam_key"}, cam_search_data_o, 0);
`ifdef CAM_REQ_SEQ_STATS_EN
    chk_val({p, "_stats"}, {stat_hits_o, stat_misses_o}, 0);
`endif
  endtask

  initial begin
    int base, n;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = '0;
      ref_vld[i] = 1'b0;
    end
    req_valid_i = 1'b0;
    req_op_i    = '0;
    req_index_i = '0;
    req_data_i  = '0;
    rsp_ready_i = 1'b1;

    fork
      begin : stimulus
        #3;
        chk_zero("rst");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        base = en_cnt;
        repeat (20) @(negedge clk_i);
        chk_val("idle_ready", req_ready_o, 1);
        chk_val("idle_rsp_valid", rsp_valid_o, 0);
        chk_val("idle_no_enable", en_cnt - base, 0);

        push_req(2'b01, 5'd5, 32'hDEADBEEF);
        push_req(2'b00, 5'd5, 32'h0);
        drain("wr_rd");
        chk_val("wr_to_rd_gap", rd_cyc - we_cyc, 1);
        chk_val("wr_idx", wr_idx_seen, 5);
        chk_val("wr_data", wr_data_seen, 32'hDEADBEEF);
        chk_val("rd_idx", rd_idx_seen, 5);

        push_req(2'b10, 5'd0, 32'hDEADBEEF);
        push_req(2'b10, 5'd0, 32'h12345678);
        drain("search");

        base = en_cnt;
        push_req(2'b01, 5'd7, 32'hA5A5_5A5A);
        push_req(2'b11, 5'd7, 32'h0000_0000);
        push_req(2'b01, 5'd8, 32'h0F0F_F0F0);
        push_req(2'b00, 5'd7, 32'h0);
        drain("rsvd");
        chk_val("rsvd_enables", en_cnt - base, 3);

        rsp_ready_i = 1'b0;
        push_req(2'b00, 5'd5, 32'h0);
        n = 0;
        while (!rsp_valid_o && n < 50) begin
          @(negedge clk_i);
          n++;
        end
        chk_val("held_rsp_arrives", rsp_valid_o, 1);
        push_req(2'b00, 5'd7, 32'h0);
        push_req(2'b00, 5'd8, 32'h0);
        push_req(2'b10, 5'd0, 32'hDEADBEEF);
        push_req(2'b00, 5'd5, 32'h0);
        chk_val("ready_full", req_ready_o, 0);
        repeat (3) begin
          @(negedge clk_i);
          chk_val("held_rsp", {rsp_valid_o, rsp_hit_o, rsp_data_o, rsp_is_search_o}, {1'b1, exp_q[0]});
        end
        rsp_ready_i = 1'b1;
        push_req(2'b00, 5'd8, 32'h0);
        drain("full");

        push_req(2'b00, 5'd5, 32'h0);
        push_req(2'b10, 5'd0, 32'h12345678);
        n = 0;
        while (!cam_read_enable_o && n < 50) begin
          @(negedge clk_i);
          n++;
        end
        chk_val("rst_wait_reached", cam_read_enable_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        base = en_cnt;
        repeat (10) @(negedge clk_i);
        chk_val("post_rst_no_enable", en_cnt - base, 0);
        chk_val("post_rst_rsp_valid", rsp_valid_o, 0);
        chk_val("post_rst_ready", req_ready_o, 1);

        push_req(2'b01, 5'd10, 32'h1111_1111);
        push_req(2'b01, 5'd11, 32'h2222_2222);
        push_req(2'b01, 5'd12, 32'h3333_3333);
        push_req(2'b10, 5'd0, 32'h1111_1111);
        push_req(2'b10, 5'd0, 32'h2222_2222);
        push_req(2'b10, 5'd0, 32'h0BAD_F00D);
        push_req(2'b10, 5'd0, 32'h3333_3333);
        push_req(2'b10, 5'd0, 32'h0BAD_F00E);
        push_req(2'b00, 5'd12, 32'h0);
        drain("stats");
`ifdef CAM_REQ_SEQ_STATS_EN
        chk_val("stat_hits", stat_hits_o, 3);
        chk_val("stat_misses", stat_misses_o, 2);
`endif
        chk_val("enable_onehot", onehot_err, 0);
        chk_val("scoreboard_empty", exp_q.size(), 0);
        done = 1'b1;
      end
      begin : monitor
        logic [33:0] e;
        while (!done) begin
          @(negedge clk_i);
          #1;
          if (rst_i) begin
            cyc++;
            if ($countones({cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}) > 1)
              onehot_err++;
            if (cam_write_enable_o) begin
              en_cnt++;
              we_cyc       = cyc;
              wr_idx_seen  = cam_write_index_o;
              wr_data_seen = cam_write_data_o;
            end
            if (cam_read_enable_o) begin
              en_cnt++;
              rd_cyc      = cyc;
              rd_idx_seen = cam_read_index_o;
            end
            if (cam_search_enable_o) en_cnt++;
            if (rsp_valid_o && rsp_ready_i) begin
              if (exp_q.size() == 0) chk_val("rsp_unexpected", 1, 0);
              else begin
                e = exp_q.pop_front();
                chk_val("rsp", {rsp_hit_o, rsp_data_o, rsp_is_search_o}, e);
              end
            end
          end
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
